// File: rtl/lsu_pkg.sv
// Shared constants and types for the load/store unit.
// Holds funct3 encodings, FSM state enum, error codes and counter width.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

    localparam int CNT_W = 8;

endpackage

// File: rtl/lsu_if.sv
// Handshake bundles: core <-> LSU request/response, and LSU <-> data memory.
// Core side: master = execute stage, slave = LSU. Memory side: master = LSU, slave = memory.
interface lsu_core_if;
    logic        lsu_valid;
    logic        lsu_ready;
    logic        lsu_store;
    logic [2:0]  lsu_funct3;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic        lsu_done;
    logic [31:0] lsu_rdata;
    logic [1:0]  lsu_err;

    modport master (
        output lsu_valid, lsu_store, lsu_funct3, lsu_addr, lsu_wdata,
        input  lsu_ready, lsu_done, lsu_rdata, lsu_err
    );
    modport slave (
        input  lsu_valid, lsu_store, lsu_funct3, lsu_addr, lsu_wdata,
        output lsu_ready, lsu_done, lsu_rdata, lsu_err
    );
endinterface

interface lsu_mem_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ack, mem_rdata
    );
    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/lsu_align.sv
// Combinational size/alignment decode: byte enables, lane-replicated store
// data, misaligned/illegal flags and sign/zero-extended load data.
module lsu_align
    import lsu_pkg::*;
(
    input  logic        store_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] mem_rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic        misalign_o,
    output logic        illegal_o,
    output logic [31:0] rdata_o
);

    logic [31:0] lane;

    // Size lives in funct3[1:0]; bit 2 is the unsigned flag, legal for
    // byte/half loads only.
    assign illegal_o = (funct3_i[1:0] == 2'b11)
                     | (funct3_i[2] & (store_i | funct3_i[1]));

    // Move the addressed byte/half down to bit 0.
    assign lane = mem_rdata_i >> {addr_i[1:0], 3'b000};

    always_comb begin
        be_o       = 4'b0000;
        wdata_o    = 32'h0;
        misalign_o = 1'b0;
        case (funct3_i[1:0])
            2'b00: begin
                be_o    = 4'b0001 << addr_i[1:0];
                wdata_o = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                be_o       = addr_i[1] ? 4'b1100 : 4'b0011;
                wdata_o    = {2{wdata_i[15:0]}};
                misalign_o = addr_i[0];
            end
            2'b10: begin
                be_o       = 4'b1111;
                wdata_o    = wdata_i;
                misalign_o = |addr_i[1:0];
            end
            default: ;
        endcase
    end

    always_comb begin
        rdata_o = 32'h0;
        case (funct3_i)
            F3_B:    rdata_o = {{24{lane[7]}}, lane[7:0]};
            F3_H:    rdata_o = {{16{lane[15]}}, lane[15:0]};
            F3_W:    rdata_o = mem_rdata_i;
            F3_BU:   rdata_o = {24'h0, lane[7:0]};
            F3_HU:   rdata_o = {16'h0, lane[15:0]};
            default: rdata_o = 32'h0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store initiator between execute stage and data memory.
// Ports: clk, rst (async high), core (lsu_core_if.slave), mem (lsu_mem_if.master).
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic       clk,
    input  logic       rst,
    lsu_core_if.slave  core,
    lsu_mem_if.master  mem
);

    state_e            state_q, state_d;
    logic              store_q, store_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        err_q, err_d;
    logic [31:0]       rdata_q, rdata_d;

    logic              idle;
    logic              in_req;
    logic              in_done;
    logic              a_store;
    logic [2:0]        a_funct3;
    logic [31:0]       a_addr;
    logic [31:0]       a_wdata;
    logic [3:0]        a_be;
    logic [31:0]       a_wrep;
    logic              a_misalign;
    logic              a_illegal;
    logic [31:0]       a_rdata;

    assign idle    = (state_q == S_IDLE);
    assign in_req  = (state_q == S_REQ);
    assign in_done = (state_q == S_DONE);

    // In IDLE the decoder checks the incoming request; afterwards it works
    // on the captured copy so the memory outputs stay stable.
    assign a_store  = idle ? core.lsu_store  : store_q;
    assign a_funct3 = idle ? core.lsu_funct3 : funct3_q;
    assign a_addr   = idle ? core.lsu_addr   : addr_q;
    assign a_wdata  = idle ? core.lsu_wdata  : wdata_q;

    lsu_align u_align (
        .store_i     (a_store),
        .funct3_i    (a_funct3),
        .addr_i      (a_addr),
        .wdata_i     (a_wdata),
        .mem_rdata_i (mem.mem_rdata),
        .be_o        (a_be),
        .wdata_o     (a_wrep),
        .misalign_o  (a_misalign),
        .illegal_o   (a_illegal),
        .rdata_o     (a_rdata)
    );

    always_comb begin
        state_d  = state_q;
        store_d  = store_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        rdata_d  = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (core.lsu_valid) begin
                    store_d  = core.lsu_store;
                    funct3_d = core.lsu_funct3;
                    addr_d   = core.lsu_addr;
                    wdata_d  = core.lsu_wdata;
                    cnt_d    = '0;
                    rdata_d  = 32'h0;
                    if (a_illegal) begin
                        err_d   = ERR_ILLEGAL;
                        state_d = S_DONE;
                    end else if (a_misalign) begin
                        err_d   = ERR_MISALIGN;
                        state_d = S_DONE;
                    end else begin
                        err_d   = ERR_OK;
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (mem.mem_ack) begin
                    rdata_d = store_q ? 32'h0 : a_rdata;
                    err_d   = ERR_OK;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    // Leaving after the count reaches the limit keeps
                    // mem_req high for exactly TIMEOUT_CYCLES cycles.
                    if (cnt_d == CNT_W'(TIMEOUT_CYCLES)) begin
                        err_d   = ERR_TIMEOUT;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            store_q  <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            cnt_q    <= '0;
            err_q    <= ERR_OK;
            rdata_q  <= 32'h0;
        end else begin
            state_q  <= state_d;
            store_q  <= store_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
        end
    end

    assign core.lsu_ready = idle;
    assign core.lsu_done  = in_done;
    assign core.lsu_rdata = in_done ? rdata_q : 32'h0;
    assign core.lsu_err   = in_done ? err_q : ERR_OK;

    assign mem.mem_req   = in_req;
    assign mem.mem_we    = in_req & store_q;
    assign mem.mem_addr  = in_req ? {addr_q[31:2], 2'b00} : 32'h0;
    assign mem.mem_be    = in_req ? a_be : 4'b0000;
    assign mem.mem_wdata = (in_req & store_q) ? a_wrep : 32'h0;

endmodule
